// File: rtl/rf_wb_scheduler_pkg.sv
// rtl/rf_wb_scheduler_pkg.sv - shared sizes, types and FSM states for the writeback scheduler
// Purpose: common widths, register index/data types and the arbitration state enum.
// Contents: XLEN, NREG, AW, STARVE_MAX_DEF, reg_idx_t, xdata_t, wb_state_e.
package rf_wb_scheduler_pkg;

  localparam int XLEN           = 32;
  localparam int NREG           = 32;
  localparam int AW             = 5;
  localparam int STARVE_MAX_DEF = 4;

  typedef logic [AW-1:0]   reg_idx_t;
  typedef logic [XLEN-1:0] xdata_t;

  // NORMAL: pipeline WB has fixed priority. FORCE: one cycle reserved for the long-latency unit.
  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/rf_wb_scheduler_if.sv
// rtl/rf_wb_scheduler_if.sv - bundle of WB, long-latency, dispatch, hazard and RF write signals
// Purpose: groups every non-clock/reset signal of the scheduler.
// Modports:
//   slave  - the scheduler: consumes pipe_*, lu_valid/lu_rd/lu_data, iss_*, chk_*;
//            drives pipe_stall, lu_ready, iss_accept, hz_stall, rf_we, rf_rd, rf_wdata.
//   master - the surrounding pipeline/long-latency unit/register file (opposite directions).
interface rf_wb_scheduler_if;
  import rf_wb_scheduler_pkg::*;

  logic     pipe_valid;
  reg_idx_t pipe_rd;
  xdata_t   pipe_data;
  logic     pipe_stall;

  logic     lu_valid;
  logic     lu_ready;
  reg_idx_t lu_rd;
  xdata_t   lu_data;

  logic     iss_valid;
  reg_idx_t iss_rd;
  logic     iss_accept;

  reg_idx_t chk_rs1;
  reg_idx_t chk_rs2;
  reg_idx_t chk_rd;
  logic     hz_stall;

  logic     rf_we;
  reg_idx_t rf_rd;
  xdata_t   rf_wdata;

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data,
    input  lu_valid, lu_rd, lu_data,
    input  iss_valid, iss_rd,
    input  chk_rs1, chk_rs2, chk_rd,
    output pipe_stall, lu_ready, iss_accept, hz_stall,
    output rf_we, rf_rd, rf_wdata
  );

  modport master (
    output pipe_valid, pipe_rd, pipe_data,
    output lu_valid, lu_rd, lu_data,
    output iss_valid, iss_rd,
    output chk_rs1, chk_rs2, chk_rd,
    input  pipe_stall, lu_ready, iss_accept, hz_stall,
    input  rf_we, rf_rd, rf_wdata
  );

endinterface

// File: rtl/rf_wb_scheduler_scoreboard.sv
// rtl/rf_wb_scheduler_scoreboard.sv - busy scoreboard for destinations of in-flight long-latency ops
// Purpose: one busy bit per architectural register, set on accepted dispatch, cleared when the
//          long-latency result is written into the register file.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   iss_valid, iss_rd  dispatch request and its destination
//   iss_accept         dispatch allowed (destination not already owned by a long op)
//   clr_en, clr_idx    release of a destination (long-latency write landing in the RF)
//   chk_rs1/rs2/rd     decode operands to look up
//   hz_stall           any nonzero looked-up register is busy
module rf_scoreboard
  import rf_wb_scheduler_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     iss_valid,
  input  reg_idx_t iss_rd,
  output logic     iss_accept,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t chk_rs1,
  input  reg_idx_t chk_rs2,
  input  reg_idx_t chk_rd,
  output logic     hz_stall
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            set_en;

  // busy[0] is never set, so x0 never looks busy and the explicit !=0 guards are belt-and-braces.
  function automatic logic is_busy(input logic [NREG-1:0] vec, input reg_idx_t idx);
    return (idx != '0) && vec[idx];
  endfunction

  assign iss_accept = iss_valid && !busy[iss_rd];
  assign set_en     = iss_accept && (iss_rd != '0);
  assign hz_stall   = is_busy(busy, chk_rs1) || is_busy(busy, chk_rs2) || is_busy(busy, chk_rd);

  // Clear is applied first so that a same-edge set of the same index wins.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_idx] = 1'b0;
    if (set_en) busy_nxt[iss_rd]  = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - register file write-port scheduler for pipeline WB and long-latency unit
// Purpose: arbitrates the single RF write port (pipeline fixed priority, anti-starvation FORCE
//          cycle for the long-latency unit), registers the write, and tracks busy destinations.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   wb          rf_wb_scheduler_if.slave: pipe_*, lu_*, iss_*, chk_*, hz_stall, rf_we/rf_rd/rf_wdata
// Parameters:
//   STARVE_MAX  consecutive refused lu_valid cycles before a FORCE cycle is taken
module rf_wb_scheduler
  import rf_wb_scheduler_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic               clk,
  input logic               rst_n,
  rf_wb_scheduler_if.slave  wb
);

  localparam int            CW      = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX - 1);

  wb_state_e     state;
  logic [CW-1:0] starve_cnt;
  logic          rf_src_lu;

  logic in_force;
  logic grant_pipe;
  logic grant_lu;
  logic lu_refused;

  // In FORCE the pipeline input is ignored entirely; the lu side gets the port if it still wants it.
  always_comb begin
    in_force   = (state == FORCE);
    grant_pipe = !in_force && wb.pipe_valid;
    grant_lu   = wb.lu_valid && (in_force || !wb.pipe_valid);
    lu_refused = wb.lu_valid && !grant_lu;
  end

  assign wb.pipe_stall = in_force;
  assign wb.lu_ready   = grant_lu;

  // Starvation FSM: counter saturates at STARVE_MAX-1; a further refusal at that value spends the
  // next cycle in FORCE. FORCE always lasts one cycle, even if lu_valid has dropped meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      case (state)
        NORMAL: begin
          if (lu_refused) begin
            if (starve_cnt == CNT_MAX) begin
              state <= FORCE;
            end else begin
              starve_cnt <= starve_cnt + CW'(1);
            end
          end else begin
            starve_cnt <= '0;
          end
        end
        FORCE: begin
          state      <= NORMAL;
          starve_cnt <= '0;
        end
        default: begin
          state      <= NORMAL;
          starve_cnt <= '0;
        end
      endcase
    end
  end

  // Write register: rd/data follow the granted source; x0 writes still handshake but never assert rf_we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.rf_we    <= 1'b0;
      wb.rf_rd    <= '0;
      wb.rf_wdata <= '0;
      rf_src_lu   <= 1'b0;
    end else begin
      if (grant_pipe) begin
        wb.rf_rd    <= wb.pipe_rd;
        wb.rf_wdata <= wb.pipe_data;
      end else if (grant_lu) begin
        wb.rf_rd    <= wb.lu_rd;
        wb.rf_wdata <= wb.lu_data;
      end
      wb.rf_we  <= (grant_pipe && (wb.pipe_rd != '0)) ||
                   (!grant_pipe && grant_lu && (wb.lu_rd != '0));
      rf_src_lu <= !grant_pipe && grant_lu;
    end
  end

  // The busy bit is released on the same edge the RF absorbs the long-latency data,
  // so readers see the new value without a bypass.
  rf_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .iss_valid  (wb.iss_valid),
    .iss_rd     (wb.iss_rd),
    .iss_accept (wb.iss_accept),
    .clr_en     (wb.rf_we && rf_src_lu),
    .clr_idx    (wb.rf_rd),
    .chk_rs1    (wb.chk_rs1),
    .chk_rs2    (wb.chk_rs2),
    .chk_rd     (wb.chk_rd),
    .hz_stall   (wb.hz_stall)
  );

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb/tb_rf_wb_scheduler.sv - self-checking bench for rf_wb_scheduler
module tb_rf_wb_scheduler;
  import rf_wb_scheduler_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rf_wb_scheduler_if bus();

  rf_wb_scheduler #(.STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.pipe_valid = 1'b0; bus.pipe_rd = '0; bus.pipe_data = '0;
    bus.lu_valid   = 1'b0; bus.lu_rd   = '0; bus.lu_data   = '0;
    bus.iss_valid  = 1'b0; bus.iss_rd  = '0;
    bus.chk_rs1 = '0; bus.chk_rs2 = '0; bus.chk_rd = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 5;
    if (bus.rf_we !== 1'b0)        begin errors++; $display("FAIL reset_rf_we got %0h want 0", bus.rf_we); end
    if (bus.rf_rd !== 5'd0)        begin errors++; $display("FAIL reset_rf_rd got %0h want 0", bus.rf_rd); end
    if (bus.rf_wdata !== 32'd0)    begin errors++; $display("FAIL reset_rf_wdata got %0h want 0", bus.rf_wdata); end
    if (bus.pipe_stall !== 1'b0)   begin errors++; $display("FAIL reset_pipe_stall got %0h want 0", bus.pipe_stall); end
    if (bus.hz_stall !== 1'b0)     begin errors++; $display("FAIL reset_hz_stall got %0h want 0", bus.hz_stall); end
    bus.lu_valid = 1'b1; bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    #1;
    checks += 2;
    if (bus.lu_ready !== 1'b1)     begin errors++; $display("FAIL reset_lu_ready got %0h want 1", bus.lu_ready); end
    if (bus.iss_accept !== 1'b1)   begin errors++; $display("FAIL reset_iss_accept got %0h want 1", bus.iss_accept); end
    clear_inputs();
    tick();
  endtask

  task automatic test_pipe_write();
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd5; bus.pipe_data = 32'hDEADBEEF;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd6; bus.lu_data = 32'h6666;
    #1;
    checks++;
    if (bus.lu_ready !== 1'b0) begin errors++; $display("FAIL pipe_lu_ready got %0h want 0", bus.lu_ready); end
    tick();
    clear_inputs();
    checks += 3;
    if (bus.rf_we !== 1'b1)            begin errors++; $display("FAIL pipe_rf_we got %0h want 1", bus.rf_we); end
    if (bus.rf_rd !== 5'd5)            begin errors++; $display("FAIL pipe_rf_rd got %0h want 5", bus.rf_rd); end
    if (bus.rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL pipe_rf_wdata got %0h want deadbeef", bus.rf_wdata); end
    tick();
    checks++;
    if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL pipe_idle_rf_we got %0h want 0", bus.rf_we); end
  endtask

  task automatic test_x0();
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd0; bus.pipe_data = 32'h55AA55AA;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    #1;
    checks++;
    if (bus.iss_accept !== 1'b1) begin errors++; $display("FAIL x0_iss_accept1 got %0h want 1", bus.iss_accept); end
    tick();
    bus.pipe_valid = 1'b0;
    #1;
    checks += 2;
    if (bus.rf_we !== 1'b0)      begin errors++; $display("FAIL x0_rf_we got %0h want 0", bus.rf_we); end
    if (bus.iss_accept !== 1'b1) begin errors++; $display("FAIL x0_iss_accept2 got %0h want 1", bus.iss_accept); end
    clear_inputs();
    tick();
  endtask

  task automatic test_scoreboard();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    #1;
    checks++;
    if (bus.iss_accept !== 1'b1) begin errors++; $display("FAIL sb_first_accept got %0h want 1", bus.iss_accept); end
    tick();
    bus.iss_valid = 1'b0; bus.chk_rs2 = 5'd7;
    #1;
    checks++;
    if (bus.hz_stall !== 1'b1) begin errors++; $display("FAIL sb_hz_busy got %0h want 1", bus.hz_stall); end
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    #1;
    checks++;
    if (bus.iss_accept !== 1'b0) begin errors++; $display("FAIL sb_waw_accept got %0h want 0", bus.iss_accept); end
    bus.iss_valid = 1'b0;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd7; bus.lu_data = 32'h1234;
    #1;
    checks++;
    if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL sb_lu_ready got %0h want 1", bus.lu_ready); end
    tick();
    bus.lu_valid = 1'b0;
    #1;
    checks += 4;
    if (bus.rf_we !== 1'b1)       begin errors++; $display("FAIL sb_lu_rf_we got %0h want 1", bus.rf_we); end
    if (bus.rf_rd !== 5'd7)       begin errors++; $display("FAIL sb_lu_rf_rd got %0h want 7", bus.rf_rd); end
    if (bus.rf_wdata !== 32'h1234) begin errors++; $display("FAIL sb_lu_rf_wdata got %0h want 1234", bus.rf_wdata); end
    if (bus.hz_stall !== 1'b1)    begin errors++; $display("FAIL sb_hz_during_we got %0h want 1", bus.hz_stall); end
    tick();
    checks++;
    if (bus.hz_stall !== 1'b0) begin errors++; $display("FAIL sb_hz_after_we got %0h want 0", bus.hz_stall); end
    clear_inputs();
  endtask

  task automatic test_starvation();
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd10; bus.pipe_data = 32'hA0A0;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd11; bus.lu_data = 32'hB1B1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks += 2;
      if (bus.lu_ready !== 1'b0)   begin errors++; $display("FAIL starve_lu_ready cyc %0d got %0h want 0", i, bus.lu_ready); end
      if (bus.pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_pipe_stall cyc %0d got %0h want 0", i, bus.pipe_stall); end
      tick();
    end
    #1;
    checks += 2;
    if (bus.pipe_stall !== 1'b1) begin errors++; $display("FAIL force_pipe_stall got %0h want 1", bus.pipe_stall); end
    if (bus.lu_ready !== 1'b1)   begin errors++; $display("FAIL force_lu_ready got %0h want 1", bus.lu_ready); end
    tick();
    bus.lu_valid = 1'b0;
    #1;
    checks += 3;
    if (bus.pipe_stall !== 1'b0) begin errors++; $display("FAIL post_force_stall got %0h want 0", bus.pipe_stall); end
    if (bus.rf_rd !== 5'd11)     begin errors++; $display("FAIL force_rf_rd got %0h want 11", bus.rf_rd); end
    if (bus.rf_wdata !== 32'hB1B1) begin errors++; $display("FAIL force_rf_wdata got %0h want b1b1", bus.rf_wdata); end
    tick();
    checks += 2;
    if (bus.rf_we !== 1'b1)  begin errors++; $display("FAIL resume_rf_we got %0h want 1", bus.rf_we); end
    if (bus.rf_rd !== 5'd10) begin errors++; $display("FAIL resume_rf_rd got %0h want 10", bus.rf_rd); end
    clear_inputs();
    tick();
  endtask

  task automatic test_same_edge();
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd9; bus.lu_data = 32'h99;
    tick();
    bus.lu_valid = 1'b0; bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    #1;
    checks += 2;
    if (bus.iss_accept !== 1'b1) begin errors++; $display("FAIL same_iss_accept got %0h want 1", bus.iss_accept); end
    if (bus.rf_rd !== 5'd9)      begin errors++; $display("FAIL same_rf_rd got %0h want 9", bus.rf_rd); end
    tick();
    bus.iss_valid = 1'b0; bus.chk_rs1 = 5'd9;
    #1;
    checks++;
    if (bus.hz_stall !== 1'b1) begin errors++; $display("FAIL same_edge_busy got %0h want 1", bus.hz_stall); end
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd9;
    tick();
    bus.lu_valid = 1'b0;
    tick();
    checks++;
    if (bus.hz_stall !== 1'b0) begin errors++; $display("FAIL same_cleanup_busy got %0h want 0", bus.hz_stall); end
    clear_inputs();
  endtask

  // Reference model: a write port owner per cycle, a count of refusals in a row, one RF write in flight.
  task automatic test_random();
    bit          m_force;
    int          m_streak;
    bit          m_busy [NREG];
    bit          m_we;
    bit          m_src_lu;
    logic [4:0]  m_rd;
    logic [31:0] m_wdata;
    bit          e_stall, e_ready, e_acc, e_hz;
    apply_reset();
    m_force = 0; m_streak = 0; m_we = 0; m_src_lu = 0; m_rd = '0; m_wdata = '0;
    for (int r = 0; r < NREG; r++) m_busy[r] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.pipe_valid = ($urandom_range(3, 0) != 0);
      bus.pipe_rd    = 5'($urandom_range(7, 0));
      bus.pipe_data  = $urandom;
      bus.lu_valid   = ($urandom_range(2, 0) != 0);
      bus.lu_rd      = 5'($urandom_range(7, 0));
      bus.lu_data    = $urandom;
      bus.iss_valid  = ($urandom_range(2, 0) == 0);
      bus.iss_rd     = 5'($urandom_range(7, 0));
      bus.chk_rs1    = 5'($urandom_range(7, 0));
      bus.chk_rs2    = 5'($urandom_range(7, 0));
      bus.chk_rd     = 5'($urandom_range(7, 0));
      #1;
      e_stall = m_force;
      e_ready = bus.lu_valid && (m_force || !bus.pipe_valid);
      e_acc   = bus.iss_valid && !m_busy[bus.iss_rd];
      e_hz    = (bus.chk_rs1 != 0 && m_busy[bus.chk_rs1]) || (bus.chk_rs2 != 0 && m_busy[bus.chk_rs2]) ||
                (bus.chk_rd != 0 && m_busy[bus.chk_rd]);
      checks += 7;
      if (bus.pipe_stall !== e_stall) begin errors++; $display("FAIL rnd_pipe_stall cyc %0d got %0h want %0h", cyc, bus.pipe_stall, e_stall); end
      if (bus.lu_ready !== e_ready)   begin errors++; $display("FAIL rnd_lu_ready cyc %0d got %0h want %0h", cyc, bus.lu_ready, e_ready); end
      if (bus.iss_accept !== e_acc)   begin errors++; $display("FAIL rnd_iss_accept cyc %0d got %0h want %0h", cyc, bus.iss_accept, e_acc); end
      if (bus.hz_stall !== e_hz)      begin errors++; $display("FAIL rnd_hz_stall cyc %0d got %0h want %0h", cyc, bus.hz_stall, e_hz); end
      if (bus.rf_we !== m_we)         begin errors++; $display("FAIL rnd_rf_we cyc %0d got %0h want %0h", cyc, bus.rf_we, m_we); end
      if (bus.rf_rd !== m_rd)         begin errors++; $display("FAIL rnd_rf_rd cyc %0d got %0h want %0h", cyc, bus.rf_rd, m_rd); end
      if (bus.rf_wdata !== m_wdata)   begin errors++; $display("FAIL rnd_rf_wdata cyc %0d got %0h want %0h", cyc, bus.rf_wdata, m_wdata); end
      // Scoreboard: release of the landing lu write, then the new dispatch (which wins on a tie).
      if (m_we && m_src_lu) m_busy[m_rd] = 0;
      if (e_acc && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1;
      // Next registered write.
      if (!m_force && bus.pipe_valid) begin
        m_we = (bus.pipe_rd != 0); m_rd = bus.pipe_rd; m_wdata = bus.pipe_data; m_src_lu = 0;
      end else if (e_ready) begin
        m_we = (bus.lu_rd != 0); m_rd = bus.lu_rd; m_wdata = bus.lu_data; m_src_lu = 1;
      end else begin
        m_we = 0; m_src_lu = 0;
      end
      // After four refusals in a row the following cycle belongs to the long-latency unit.
      if (m_force) begin
        m_force = 0; m_streak = 0;
      end else if (bus.lu_valid && !e_ready) begin
        m_streak++;
        if (m_streak >= 4) begin m_force = 1; m_streak = 0; end
      end else begin
        m_streak = 0;
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    tick();
    bus.iss_valid = 1'b0;
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd12; bus.pipe_data = 32'hC0FFEE;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd4; bus.lu_data = 32'h44;
    bus.chk_rs1 = 5'd3;
    repeat (4) tick();
    #1;
    checks += 3;
    if (bus.pipe_stall !== 1'b1) begin errors++; $display("FAIL ar_pre_force got %0h want 1", bus.pipe_stall); end
    if (bus.rf_we !== 1'b1)      begin errors++; $display("FAIL ar_pre_rf_we got %0h want 1", bus.rf_we); end
    if (bus.hz_stall !== 1'b1)   begin errors++; $display("FAIL ar_pre_busy got %0h want 1", bus.hz_stall); end
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (bus.rf_we !== 1'b0)      begin errors++; $display("FAIL ar_rf_we got %0h want 0", bus.rf_we); end
    if (bus.pipe_stall !== 1'b0) begin errors++; $display("FAIL ar_pipe_stall got %0h want 0", bus.pipe_stall); end
    if (bus.hz_stall !== 1'b0)   begin errors++; $display("FAIL ar_busy3 got %0h want 0", bus.hz_stall); end
    if (bus.lu_ready !== 1'b0)   begin errors++; $display("FAIL ar_lu_ready got %0h want 0", bus.lu_ready); end
    rst_n = 1'b1;
    // Counter restarted from zero: four more refused cycles before FORCE.
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (bus.pipe_stall !== 1'b0) begin errors++; $display("FAIL ar_cnt_stall cyc %0d got %0h want 0", k, bus.pipe_stall); end
      tick();
    end
    #1;
    checks++;
    if (bus.pipe_stall !== 1'b1) begin errors++; $display("FAIL ar_cnt_force got %0h want 1", bus.pipe_stall); end
    clear_inputs();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clear_inputs();
    test_reset();
    test_pipe_write();
    test_x0();
    test_scoreboard();
    test_starvation();
    test_same_edge();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
